// File: rtl/regfile_wb_arbiter.sv
// Round-robin arbiter sharing the register-file write port between two
// writeback requesters, with a pending-destination scoreboard for decode.
// Optional forwarding from the write stage: define REGFILE_BYPASS_EN.
module regfile_wb_arbiter #(
   parameter int XLEN = 32,
   parameter int NREG = 32
) (
   input  logic            i_clk,
   input  logic            i_rst,
   input  logic            i_a_valid,
   input  logic [4:0]      i_a_rd,
   input  logic [XLEN-1:0] i_a_data,
   output logic            o_a_ready,
   input  logic            i_b_valid,
   input  logic [4:0]      i_b_rd,
   input  logic [XLEN-1:0] i_b_data,
   output logic            o_b_ready,
   output logic [4:0]      o_waddr,
   output logic [XLEN-1:0] o_wdata,
   output logic            o_write,
   input  logic            i_issue,
   input  logic [4:0]      i_issue_rd,
   input  logic [4:0]      i_rs1,
   input  logic [4:0]      i_rs2,
   output logic            o_stall,
   output logic            o_fwd1_valid,
   output logic            o_fwd2_valid,
   output logic [XLEN-1:0] o_fwd_data
);

   typedef enum logic {
      GNT_A = 1'b0,
      GNT_B = 1'b1
   } gnt_e;

   gnt_e            last_q;
   logic            wr_q;
   logic [4:0]      waddr_q;
   logic [XLEN-1:0] wdata_q;
   logic [NREG-1:0] pend_q;
   logic [NREG-1:0] pend_d;

   logic            grant_a;
   logic            grant_b;
   logic [4:0]      sel_rd;
   logic [XLEN-1:0] sel_data;
   logic            fwd1;
   logic            fwd2;

   // Readies are masked during reset so requesters keep presenting across it.
   always_comb begin
      grant_a = !i_rst && i_a_valid && (!i_b_valid || (last_q == GNT_B));
      grant_b = !i_rst && i_b_valid && !grant_a;
      sel_rd   = grant_a ? i_a_rd   : i_b_rd;
      sel_data = grant_a ? i_a_data : i_b_data;
   end

   assign o_a_ready = grant_a;
   assign o_b_ready = grant_b;

   // Clear from the committing write first, so a same-edge reservation wins.
   always_comb begin
      pend_d = pend_q;
      if (wr_q) begin
         pend_d[waddr_q] = 1'b0;
      end
      if (i_issue && (i_issue_rd != '0)) begin
         pend_d[i_issue_rd] = 1'b1;
      end
      pend_d[0] = 1'b0;
   end

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         last_q  <= GNT_B;
         wr_q    <= 1'b0;
         waddr_q <= '0;
         wdata_q <= '0;
         pend_q  <= '0;
      end else begin
         pend_q <= pend_d;
         wr_q   <= (grant_a || grant_b) && (sel_rd != '0);
         if (grant_a) begin
            last_q <= GNT_A;
         end else if (grant_b) begin
            last_q <= GNT_B;
         end
         if ((grant_a || grant_b) && (sel_rd != '0)) begin
            waddr_q <= sel_rd;
            wdata_q <= sel_data;
         end
      end
   end

   assign o_write = wr_q;
   assign o_waddr = waddr_q;
   assign o_wdata = wdata_q;

`ifdef REGFILE_BYPASS_EN
   assign fwd1       = wr_q && (waddr_q != '0) && (waddr_q == i_rs1);
   assign fwd2       = wr_q && (waddr_q != '0) && (waddr_q == i_rs2);
   assign o_fwd_data = wdata_q;
`else
   assign fwd1       = 1'b0;
   assign fwd2       = 1'b0;
   assign o_fwd_data = '0;
`endif

   assign o_fwd1_valid = fwd1;
   assign o_fwd2_valid = fwd2;
   assign o_stall = ((i_rs1 != '0) && pend_q[i_rs1] && !fwd1) ||
                    ((i_rs2 != '0) && pend_q[i_rs2] && !fwd2);

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Self-checking bench for regfile_wb_arbiter: directed scenarios with literal
// expectations plus randomized traffic checked against a behavioural model.
module tb_regfile_wb_arbiter;

   logic        clk = 1'b0;
   logic        rst;
   logic        a_valid, b_valid, a_ready, b_ready;
   logic [4:0]  a_rd, b_rd, waddr, issue_rd, rs1, rs2;
   logic [31:0] a_data, b_data, wdata, fwd_data;
   logic        write, issue, stall, fwd1, fwd2;

   regfile_wb_arbiter #(.XLEN(32), .NREG(32)) dut (
      .i_clk(clk), .i_rst(rst),
      .i_a_valid(a_valid), .i_a_rd(a_rd), .i_a_data(a_data), .o_a_ready(a_ready),
      .i_b_valid(b_valid), .i_b_rd(b_rd), .i_b_data(b_data), .o_b_ready(b_ready),
      .o_waddr(waddr), .o_wdata(wdata), .o_write(write),
      .i_issue(issue), .i_issue_rd(issue_rd), .i_rs1(rs1), .i_rs2(rs2),
      .o_stall(stall), .o_fwd1_valid(fwd1), .o_fwd2_valid(fwd2), .o_fwd_data(fwd_data)
   );

   always #5 clk = ~clk;

`ifdef REGFILE_BYPASS_EN
   localparam bit BYP = 1'b1;
`else
   localparam bit BYP = 1'b0;
`endif

   int n_vec = 0;
   int n_fail = 0;

   // Behavioural model: which requester has priority, what the write stage
   // holds, and the set of reserved destinations.
   bit          m_pend[32];
   bit          m_prefer_a;
   bit          m_wr;
   int          m_waddr;
   logic [31:0] m_wdata;
   bit          m_known;
   bit          m_ga, m_gb;

   logic        cap_ar, cap_br, cap_wr, cap_st, cap_f1, cap_f2;
   logic [4:0]  cap_wa;
   logic [31:0] cap_wd, cap_fd;

   task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s at %0t: got 0x%0h expected 0x%0h", name, $time, got, exp);
      end
   endtask

   task automatic tick();
      bit ga, gb, f1, f2, st;
      @(negedge clk);
      cap_ar = a_ready; cap_br = b_ready; cap_wr = write; cap_wa = waddr;
      cap_wd = wdata; cap_st = stall; cap_f1 = fwd1; cap_f2 = fwd2; cap_fd = fwd_data;

      ga = !rst && a_valid && (!b_valid || m_prefer_a);
      gb = !rst && b_valid && !ga;
      f1 = BYP && m_wr && (m_waddr != 0) && (m_waddr == int'(rs1));
      f2 = BYP && m_wr && (m_waddr != 0) && (m_waddr == int'(rs2));
      st = ((rs1 != 0) && m_pend[rs1] && !f1) || ((rs2 != 0) && m_pend[rs2] && !f2);
      check("a_ready", 32'(cap_ar), 32'(ga));
      check("b_ready", 32'(cap_br), 32'(gb));
      check("write", 32'(cap_wr), 32'(m_wr));
      check("stall", 32'(cap_st), 32'(st));
      check("fwd1", 32'(cap_f1), 32'(f1));
      check("fwd2", 32'(cap_f2), 32'(f2));
      if (m_known) begin
         check("waddr", 32'(cap_wa), 32'(m_waddr));
         check("wdata", cap_wd, m_wdata);
         check("fwd_data", cap_fd, BYP ? m_wdata : 32'h0);
      end
      m_ga = ga;
      m_gb = gb;
      n_vec++;

      if (rst) begin
         foreach (m_pend[i]) m_pend[i] = 1'b0;
         m_prefer_a = 1'b1;
         m_wr = 1'b0; m_waddr = 0; m_wdata = '0; m_known = 1'b1;
      end else begin
         if (m_wr) m_pend[m_waddr] = 1'b0;
         if (issue && issue_rd != 0) m_pend[issue_rd] = 1'b1;
         if (ga || gb) begin
            m_prefer_a = gb;
            m_wr = (ga ? a_rd : b_rd) != 0;
            if (m_wr) begin
               m_waddr = ga ? int'(a_rd) : int'(b_rd);
               m_wdata = ga ? a_data : b_data;
               m_known = 1'b1;
            end else begin
               m_known = 1'b0;
            end
         end else begin
            m_wr = 1'b0;
         end
      end
      @(posedge clk);
      #1;
   endtask

   task automatic idle_inputs();
      a_valid = 0; a_rd = 0; a_data = 0;
      b_valid = 0; b_rd = 0; b_data = 0;
      issue = 0; issue_rd = 0; rs1 = 0; rs2 = 0;
   endtask

   task automatic do_reset();
      rst = 1'b1;
      tick();
      rst = 1'b0;
   endtask

   bit          ar_at[12], br_at[12], wr_at[12];
   logic [4:0]  wa_at[12];

   initial begin
      int ai, bi;
      logic [4:0] ard[4], brd[4];
      m_known = 1'b0;
      idle_inputs();
      rst = 1'b1;
      #1;
      tick();
      tick();
      rst = 1'b0;
      tick();
      check("reset_write", 32'(cap_wr), 32'd0);
      check("reset_waddr", 32'(cap_wa), 32'd0);
      check("reset_wdata", cap_wd, 32'd0);

      // A alone
      a_valid = 1; a_rd = 5; a_data = 32'h1234;
      tick();
      check("t1_a_ready", 32'(cap_ar), 32'd1);
      a_valid = 0;
      tick();
      check("t1_write", 32'(cap_wr), 32'd1);
      check("t1_waddr", 32'(cap_wa), 32'd5);
      check("t1_wdata", cap_wd, 32'h1234);
      tick();
      check("t1_write_off", 32'(cap_wr), 32'd0);
      check("t1_hold_waddr", 32'(cap_wa), 32'd5);

      // Both requesters streaming
      do_reset();
      ard = '{5'd1, 5'd2, 5'd3, 5'd4};
      brd = '{5'd9, 5'd10, 5'd11, 5'd12};
      ai = 0; bi = 0;
      for (int c = 0; c < 12; c++) begin
         a_valid = ai < 4; a_rd = ard[ai % 4]; a_data = 32'h100 + 32'(ai);
         b_valid = bi < 4; b_rd = brd[bi % 4]; b_data = 32'h200 + 32'(bi);
         tick();
         ar_at[c] = cap_ar; br_at[c] = cap_br; wr_at[c] = cap_wr; wa_at[c] = cap_wa;
         if (cap_ar) ai++;
         if (cap_br) bi++;
      end
      idle_inputs();
      check("t2_all_a_done", 32'(ai), 32'd4);
      check("t2_all_b_done", 32'(bi), 32'd4);
      check("t2_grant0_a", 32'(ar_at[0]), 32'd1);
      check("t2_grant1_b", 32'(br_at[1]), 32'd1);
      check("t2_grant2_a", 32'(ar_at[2]), 32'd1);
      check("t2_grant3_b", 32'(br_at[3]), 32'd1);
      check("t2_nowrite_c0", 32'(wr_at[0]), 32'd0);
      check("t2_write_c1", 32'({wr_at[1], wr_at[2], wr_at[3], wr_at[4]}), 32'hf);
      check("t2_waddr_c1", 32'(wa_at[1]), 32'd1);
      check("t2_waddr_c2", 32'(wa_at[2]), 32'd9);
      check("t2_waddr_c3", 32'(wa_at[3]), 32'd2);
      check("t2_waddr_c4", 32'(wa_at[4]), 32'd10);

      // B writes x0
      b_valid = 1; b_rd = 0; b_data = 32'hFFFF_FFFF;
      tick();
      check("t3_b_ready", 32'(cap_br), 32'd1);
      b_valid = 0;
      tick();
      check("t3_write", 32'(cap_wr), 32'd0);

      // Scoreboard stall and release
      issue = 1; issue_rd = 7;
      tick();
      issue = 0; rs1 = 7;
      tick();
      check("t4_stall_pend", 32'(cap_st), 32'd1);
      a_valid = 1; a_rd = 7; a_data = 32'h77;
      tick();
      check("t4_a_ready", 32'(cap_ar), 32'd1);
      check("t4_stall_grant", 32'(cap_st), 32'd1);
      a_valid = 0;
      tick();
      check("t4_write", 32'(cap_wr), 32'd1);
      check("t4_stall_wr", 32'(cap_st), BYP ? 32'd0 : 32'd1);
      check("t4_fwd1", 32'(cap_f1), BYP ? 32'd1 : 32'd0);
      tick();
      check("t4_stall_after", 32'(cap_st), 32'd0);
      rs1 = 0;

      // Same-edge reserve and commit of x3
      issue = 1; issue_rd = 3;
      tick();
      issue = 0;
      a_valid = 1; a_rd = 3; a_data = 32'h33;
      tick();
      a_valid = 0; issue = 1; issue_rd = 3;
      tick();
      check("t5_write", 32'(cap_wr), 32'd1);
      check("t5_waddr", 32'(cap_wa), 32'd3);
      issue = 0; rs2 = 3;
      tick();
      check("t5_stall", 32'(cap_st), 32'd1);
      rs2 = 0;

      // Reset with a write in flight
      issue = 1; issue_rd = 8;
      tick();
      issue = 0;
      a_valid = 1; a_rd = 8; a_data = 32'h88;
      tick();
      a_valid = 0; rst = 1;
      tick();
      rst = 0; rs1 = 8;
      tick();
      check("t6_write", 32'(cap_wr), 32'd0);
      check("t6_stall", 32'(cap_st), 32'd0);
      rs1 = 0;
      a_valid = 1; a_rd = 20; a_data = 32'hA;
      b_valid = 1; b_rd = 21; b_data = 32'hB;
      tick();
      check("t6_first_a", 32'(cap_ar), 32'd1);
      check("t6_first_not_b", 32'(cap_br), 32'd0);
      a_valid = 0;
      tick();
      check("t6_then_b", 32'(cap_br), 32'd1);
      idle_inputs();
      tick();

      // Randomized traffic
      for (int c = 0; c < 3000; c++) begin
         rst = ($urandom_range(0, 99) == 0);
         if (!a_valid || m_ga) begin
            a_valid = $urandom_range(0, 9) < 7;
            a_rd = 5'($urandom_range(0, 31));
            a_data = $urandom;
         end
         if (!b_valid || m_gb) begin
            b_valid = $urandom_range(0, 9) < 6;
            b_rd = 5'($urandom_range(0, 31));
            b_data = $urandom;
         end
         issue_rd = 5'($urandom_range(0, 31));
         issue = ($urandom_range(0, 9) < 4) && !m_pend[issue_rd];
         rs1 = $urandom_range(0, 1) ? 5'($urandom_range(0, 7)) : 5'($urandom_range(0, 31));
         rs2 = $urandom_range(0, 1) ? 5'($urandom_range(0, 7)) : 5'($urandom_range(0, 31));
         tick();
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
      $finish;
   end

endmodule

// File: doc/regfile_wb_arbiter.md
Name: regfile_wb_arbiter

Overview:
Shares the register file's single write port between two writeback requesters: port A (ALU/CSR result) and port B (load unit). Round-robin arbitration feeds one registered write stage. A pending-destination scoreboard tells decode when a source register still waits on an in-flight result. Sits between the execute/memory stages and the register file write port (i_waddr/i_wdata/i_write).

Parameters:
XLEN, 32, data width of writeback values and of o_wdata
NREG, 32, number of architectural registers; index width is 5, and x0 is hardwired zero

Ports:
i_clk  in  1  clock, all state on rising edge
i_rst  in  1  synchronous reset, active-high
i_a_valid  in  1  requester A has a result
i_a_rd  in  5  requester A destination
i_a_data  in  XLEN  requester A value
o_a_ready  out  1  A accepted this cycle
i_b_valid  in  1  requester B has a result
i_b_rd  in  5  requester B destination
i_b_data  in  XLEN  requester B value
o_b_ready  out  1  B accepted this cycle
o_waddr  out  5  to regfile write address
o_wdata  out  XLEN  to regfile write data
o_write  out  1  to regfile write enable
i_issue  in  1  decode issues an instruction that writes i_issue_rd
i_issue_rd  in  5  destination being reserved
i_rs1  in  5  decode source 1
i_rs2  in  5  decode source 2
o_stall  out  1  a source is pending
o_fwd1_valid  out  1  bypass hit on rs1 (feature only)
o_fwd2_valid  out  1  bypass hit on rs2 (feature only)
o_fwd_data  out  XLEN  bypass value (feature only)

Behaviour:
- Reset (i_rst=1 at an edge): o_write=0, o_waddr=0, o_wdata=0, all pending bits=0, last_grant=B (so A has priority first). i_rst overrides every other input in that cycle.
- Arbitration, combinational:
  - Only one valid: that requester is granted.
  - Both valid: grant the requester not equal to last_grant.
  - o_a_ready = grant_a; o_b_ready = grant_b. At most one is high per cycle.
  - A requester holds valid, rd and data stable until it sees ready.
- last_grant updates to the granted requester on every grant edge. It is unchanged when no request is present.
- Write stage, 1-cycle latency: the edge after a grant gives o_write=1, o_waddr=rd, o_wdata=data.
  - Grant with rd=0: the requester is still acknowledged, but o_write=0 next cycle (no x0 write).
  - No grant: o_write=0 next cycle. o_waddr/o_wdata hold their previous values.
  - Sustained throughput: one write per cycle.
- Scoreboard: pending[1..31], one bit per register.
  - Set on edge with i_issue=1 and i_issue_rd!=0.
  - Cleared on edge where o_write=1 for o_waddr.
  - Set and clear of the same register at the same edge: set wins (new producer).
  - pending[0] is constant 0.
- o_stall = (i_rs1!=0 && pending[i_rs1]) || (i_rs2!=0 && pending[i_rs2]). Combinational.
- No ordering enforcement between A and B for the same rd. Decode prevents WAW by stalling on a pending rd; i_issue is never asserted for a pending rd.
- Reset mid-operation: any in-flight write stage entry is dropped, o_write=0 next cycle, scoreboard cleared. Requesters must re-present after reset.

Optional Feature:
REGFILE_BYPASS_EN.
- Defined:
  - o_fwd1_valid = o_write && o_waddr!=0 && o_waddr==i_rs1.
  - o_fwd2_valid is the same check against i_rs2.
  - o_fwd_data = o_wdata.
  - o_stall ignores a pending source that is satisfied by a forward hit in the same cycle.
- Undefined: o_fwd1_valid=0, o_fwd2_valid=0, o_fwd_data=0. o_stall uses pending bits only, so decode waits one extra cycle after the write commits.

Test Plan:
1. Reset, then A only: A valid rd=5 data=0x1234 -> o_a_ready=1 that cycle; next cycle o_write=1, o_waddr=5, o_wdata=0x1234; following cycle o_write=0.
2. A and B both valid for 4 cycles (A rd=1..4, B rd=9..12, each held until ready) -> grants A,B,A,B; o_write high 4 consecutive cycles starting cycle 2, addresses 1,9,2,10.
3. B valid rd=0 data=0xFFFF_FFFF -> o_b_ready=1; next cycle o_write=0; scoreboard unchanged.
4. Issue rd=7; next cycle i_rs1=7 -> o_stall=1. A writes rd=7 -> o_stall stays 1 through the o_write cycle (macro off) or drops in the o_write cycle with o_fwd1_valid=1 (macro on). o_stall=0 the cycle after in both cases.
5. Same edge: i_issue rd=3 and o_write waddr=3 -> pending[3]=1 afterwards; i_rs2=3 gives o_stall=1.
6. Grant A rd=8, assert i_rst the next cycle -> o_write=0 after the reset edge, all pending bits 0, next dual request granted to A first.
